// File: rtl/aes128_encrypt_iter.sv
// Iterative AES-128 encryption core, one round per clock.
// The state register is loaded with in_data ^ rk0 when a block is accepted.
// Ten rounds follow, and the ciphertext is held until downstream takes it.
// Optional build macro AES_ENC_KEY_LATCH_EN: when defined, the expanded key is
// captured when the block is accepted. Without it, round keys are read live.
module aes128_encrypt_iter #(
    parameter int NR    = 10,
    parameter int KEY_W = 1408
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [KEY_W-1:0]   expanded_key,
    input  logic               key_valid,
    input  logic [127:0]       in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [127:0]       out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy
);

    // state | meaning
    // IDLE  | waiting for a plaintext block (needs key_valid)
    // ROUND | applying rounds 1..NR, one per clock
    // DONE  | ciphertext presented, waiting for out_ready
    typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

    localparam logic [3:0] LAST = 4'(NR);

    // S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    fsm_t             fsm;
    logic [127:0]     state_reg;
    logic [3:0]       rcnt;
    logic             armed;
    logic [KEY_W-1:0] round_keys;
    logic [127:0]     round_out;

    function automatic logic [7:0] sbox(input logic [7:0] v);
        return SBOX[{~v, 3'b111} -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // SubBytes, ShiftRows, MixColumns (skipped on the last round), AddRoundKey
    function automatic logic [127:0] aes_round(input logic [127:0] st,
                                               input logic [127:0] rk,
                                               input logic         last);
        logic [7:0]   subs [16];
        logic [7:0]   shft [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        res = '0;
        for (int k = 0; k < 16; k++) subs[k] = sbox(st[127-8*k -: 8]);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                shft[r+4*c] = subs[r+4*((c+r)%4)];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                a0 = shft[4*c+r];
                a1 = shft[4*c+(r+1)%4];
                a2 = shft[4*c+(r+2)%4];
                a3 = shft[4*c+(r+3)%4];
                res[127-8*(r+4*c) -: 8] = last ? a0 : (xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3);
            end
        return res ^ rk;
    endfunction

`ifdef AES_ENC_KEY_LATCH_EN
    logic [KEY_W-1:0] key_reg;

    // capture the whole key schedule with the block so upstream may move on
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            key_reg <= '0;
        else if (fsm == IDLE && in_valid && in_ready)
            key_reg <= expanded_key;
    end

    assign round_keys = key_reg;
`else
    assign round_keys = expanded_key;
`endif

    // armed keeps in_ready low until the first edge after reset releases
    assign in_ready = armed && (fsm == IDLE) && key_valid;

    // next state value for the current round
    always_comb begin
        round_out = aes_round(state_reg, round_keys[128*rcnt +: 128], rcnt == LAST);
    end

    // sequencer: accept, iterate rounds, hold result until consumed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm       <= IDLE;
            state_reg <= '0;
            rcnt      <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            armed     <= 1'b0;
        end else begin
            armed <= 1'b1;
            unique case (fsm)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        state_reg <= in_data ^ expanded_key[127:0];
                        rcnt      <= 4'd1;
                        busy      <= 1'b1;
                        fsm       <= ROUND;
                    end
                end
                ROUND: begin
                    state_reg <= round_out;
                    rcnt      <= rcnt + 4'd1;
                    if (rcnt == LAST) begin
                        out_data  <= round_out;
                        out_valid <= 1'b1;
                        rcnt      <= '0;
                        fsm       <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        fsm       <= IDLE;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule
